// File: rtl/rr_arbiter4_if.sv
// ============================================================================
// rr_arbiter4_if : request/grant bundle shared by rr_arbiter4 and its requesters
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface rr_arbiter4_if;
   logic [3:0] req;
   logic       done;
   logic [3:0] gnt;
   logic [1:0] gnt_id;
   logic       busy;
   logic       timeout;

   modport master (
      output req,
      output done,
      input  gnt,
      input  gnt_id,
      input  busy,
      input  timeout
   );

   modport slave (
      input  req,
      input  done,
      output gnt,
      output gnt_id,
      output busy,
      output timeout
   );
endinterface

`default_nettype wire

// File: rtl/rr_arbiter4.sv
// ============================================================================
// rr_arbiter4 : four-requester round-robin arbiter, watchdog under ARB_TIMEOUT_EN
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module rr_arbiter4 #(
   parameter int MAX_HOLD = 8
) (
   input  wire logic    clk,
   input  wire logic    rst_n,
   rr_arbiter4_if.slave bus
);

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_GRANT = 1'b1
   } state_t;

   state_t     state_q, state_d;
   logic [1:0] ptr_q, ptr_d;
   logic [1:0] gnt_id_q, gnt_id_d;
   logic [3:0] gnt_q, gnt_d;
   logic       busy_q, busy_d;
   logic       timeout_q, timeout_d;

   logic [1:0] w_win;
   logic       w_any_req;
   logic       w_release;
   logic       w_hold_exp;

   // Lowest rotated offset from ptr wins, so scan offsets high-to-low and let the last hit stand.
   always_comb begin
      w_win = ptr_q;
      for (int k = 3; k >= 0; k--) begin
         if (bus.req[ptr_q + 2'(k)]) begin
            w_win = ptr_q + 2'(k);
         end
      end
   end

   assign w_any_req = |bus.req;
   assign w_release = bus.done | ~bus.req[gnt_id_q];

`ifdef ARB_TIMEOUT_EN
   localparam int              CNT_W     = $clog2(MAX_HOLD);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

   logic [CNT_W-1:0] hold_q, hold_d;

   always_comb begin
      hold_d = '0;
      if (state_q == S_GRANT) begin
         hold_d = hold_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_q <= '0;
      end else begin
         hold_q <= hold_d;
      end
   end

   assign w_hold_exp = (hold_q == HOLD_LAST);
`else
   logic w_unused_hold;

   assign w_unused_hold = (MAX_HOLD > 0);
   assign w_hold_exp    = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      gnt_id_d  = gnt_id_q;
      gnt_d     = gnt_q;
      busy_d    = busy_q;
      timeout_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (w_any_req) begin
               gnt_id_d = w_win;
               gnt_d    = 4'b0001 << w_win;
               busy_d   = 1'b1;
               state_d  = S_GRANT;
            end
         end
         S_GRANT: begin
            if (w_release || w_hold_exp) begin
               // A normal release takes precedence, so a coincident watchdog expiry stays silent.
               timeout_d = w_hold_exp & ~w_release;
               gnt_d     = 4'b0000;
               busy_d    = 1'b0;
               ptr_d     = gnt_id_q + 2'd1;
               state_d   = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            gnt_d   = 4'b0000;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         ptr_q     <= 2'b00;
         gnt_id_q  <= 2'b00;
         gnt_q     <= 4'b0000;
         busy_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         gnt_id_q  <= gnt_id_d;
         gnt_q     <= gnt_d;
         busy_q    <= busy_d;
         timeout_q <= timeout_d;
      end
   end

   assign bus.gnt     = gnt_q;
   assign bus.gnt_id  = gnt_id_q;
   assign bus.busy    = busy_q;
   assign bus.timeout = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_rr_arbiter4.sv
// ============================================================================
// tb_rr_arbiter4 : scoreboard bench for rr_arbiter4 (honours ARB_TIMEOUT_EN)
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_rr_arbiter4;

   localparam int MAX_HOLD = 4;
`ifdef ARB_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] exp_q[$];

   // Reference model state
   logic [1:0] m_ptr;
   logic [1:0] m_id;
   logic [3:0] m_gnt;
   logic       m_busy;
   logic       m_tmo;
   int         m_cnt;

   rr_arbiter4_if bus ();

   rr_arbiter4 #(.MAX_HOLD(MAX_HOLD)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [7:0] observed();
      return {bus.gnt, bus.gnt_id, bus.busy, bus.timeout};
   endfunction

   task automatic push_expected();
      exp_q.push_back({m_gnt, m_id, m_busy, m_tmo});
   endtask

   task automatic pop_check();
      if (exp_q.size() == 0) begin
         check("sb_empty", 32'd1, 32'd0);
      end else begin
         check("out", observed(), exp_q.pop_front());
      end
   endtask

   task automatic model_reset();
      m_ptr  = 2'd0;
      m_id   = 2'd0;
      m_gnt  = 4'd0;
      m_busy = 1'b0;
      m_tmo  = 1'b0;
      m_cnt  = 0;
      push_expected();
   endtask

   task automatic model_step(input logic [3:0] r, input logic d);
      logic [1:0] idx;
      bit found;
      bit rel;
      bit to;
      found = 1'b0;
      m_tmo = 1'b0;
      if (!m_busy) begin
         for (int k = 0; k < 4; k++) begin
            idx = m_ptr + 2'(k);
            if (!found && r[idx]) begin
               found = 1'b1;
               m_id  = idx;
            end
         end
         if (found) begin
            m_gnt  = 4'b0001 << m_id;
            m_busy = 1'b1;
            m_cnt  = 0;
         end
      end else begin
         rel = d || !r[m_id];
         to  = TMO_EN && (m_cnt == MAX_HOLD - 1);
         if (rel || to) begin
            m_tmo  = to && !rel;
            m_gnt  = 4'd0;
            m_busy = 1'b0;
            m_ptr  = m_id + 2'd1;
         end else begin
            m_cnt++;
         end
      end
      push_expected();
   endtask

   task automatic cycle(input logic [3:0] r, input logic d);
      bus.req  = r;
      bus.done = d;
      model_step(r, d);
      @(posedge clk);
      #1;
      pop_check();
   endtask

   // Reset is asserted between edges so its effect is visible before any clock.
   task automatic do_reset();
      bus.req  = 4'd0;
      bus.done = 1'b0;
      rst_n    = 1'b0;
      #1;
      model_reset();
      pop_check();
      check("rst_gnt", {28'd0, bus.gnt}, 32'd0);
      check("rst_busy", {31'd0, bus.busy}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      logic [3:0] rot_tab [5];
      int hold;
      bit tmo_seen;

      rot_tab[0] = 4'b0001;
      rot_tab[1] = 4'b0010;
      rot_tab[2] = 4'b0100;
      rot_tab[3] = 4'b1000;
      rot_tab[4] = 4'b0001;

      bus.req  = 4'd0;
      bus.done = 1'b0;
      #2;
      do_reset();

      cycle(4'b0000, 1'b1);
      cycle(4'b0000, 1'b0);

      // Fair rotation with all requesters active
      for (int i = 0; i < 5; i++) begin
         cycle(4'b1111, 1'b0);
         check("rot_gnt", {28'd0, bus.gnt}, {28'd0, rot_tab[i]});
         cycle(4'b1111, 1'b1);
         check("rot_idle", {28'd0, bus.gnt}, 32'd0);
      end

      // Pointer wrap after owner 3, then skip of unrequested lines
      cycle(4'b1000, 1'b0);
      check("wrap_g3", {28'd0, bus.gnt}, 32'h8);
      cycle(4'b1000, 1'b1);
      cycle(4'b0101, 1'b0);
      check("wrap_g0", {28'd0, bus.gnt}, 32'h1);
      cycle(4'b0101, 1'b1);
      cycle(4'b0101, 1'b0);
      check("skip_g2", {28'd0, bus.gnt}, 32'h4);

      // Owner 2 withdraws its request
      cycle(4'b0001, 1'b0);
      check("wd_rel", {28'd0, bus.gnt}, 32'h0);
      check("wd_id", {30'd0, bus.gnt_id}, 32'h2);
      cycle(4'b1001, 1'b0);
      check("wd_next", {28'd0, bus.gnt}, 32'h8);
      cycle(4'b1001, 1'b1);
      cycle(4'b0000, 1'b0);

      // Hold without done
      hold     = 0;
      tmo_seen = 1'b0;
`ifdef ARB_TIMEOUT_EN
      cycle(4'b0001, 1'b0);
      for (int i = 0; i < 20 && bus.gnt != 4'd0; i++) begin
         hold++;
         cycle(4'b0001, 1'b0);
      end
      check("tmo_hold", hold, MAX_HOLD);
      check("tmo_pulse", {31'd0, bus.timeout}, 32'd1);
      cycle(4'b0000, 1'b0);
      check("tmo_clear", {31'd0, bus.timeout}, 32'd0);

      // done coincides with the watchdog expiry
      cycle(4'b0001, 1'b0);
      for (int i = 0; i < MAX_HOLD - 1; i++) begin
         cycle(4'b0001, 1'b0);
      end
      cycle(4'b0001, 1'b1);
      check("coin_gnt", {28'd0, bus.gnt}, 32'd0);
      check("coin_tmo", {31'd0, bus.timeout}, 32'd0);
      cycle(4'b0000, 1'b0);
`else
      for (int i = 0; i < 100; i++) begin
         cycle(4'b0001, 1'b0);
         if (bus.gnt == 4'b0001) hold++;
         if (bus.timeout) tmo_seen = 1'b1;
      end
      check("hold_100", hold, 100);
      check("no_tmo", {31'd0, tmo_seen}, 32'd0);
      cycle(4'b0000, 1'b0);
`endif

      // Random traffic against the model
      for (int i = 0; i < 300; i++) begin
         cycle(4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));
      end

      // Asynchronous reset in the middle of a grant
      cycle(4'b0000, 1'b0);
      cycle(4'b0000, 1'b0);
      cycle(4'b0100, 1'b0);
      check("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
      do_reset();
      cycle(4'b1010, 1'b0);
      check("post_rst_gnt", {28'd0, bus.gnt}, 32'h2);
      check("post_rst_id", {30'd0, bus.gnt_id}, 32'h1);
      cycle(4'b1010, 1'b1);

      check("sb_drained", exp_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
